sram_req_arbiter: RTL
=====================

SRAM_REQ_ARBITER -- requirements
Module: sram_req_arbiter

Interface
REQ-001 Parameter ORD_DEPTH, default 4, SHALL set the number of outstanding accepted-but-unanswered requests (power of 2, 2..8).
REQ-002 Parameter STARVE_LIMIT, default 8, SHALL set the consecutive inst losses that force an inst grant.
REQ-003 aclk  input  1  clock; all state updates on its rising edge.
REQ-004 aresetn  input  1  reset; synchronous, active-low.
REQ-005 inst_sram_req  input  1  instruction fetch request (read-only requester).
REQ-006 inst_sram_addr  input  32  fetch address.
REQ-007 inst_sram_addr_ok / inst_sram_data_ok  output  1/1  inst address accepted / inst read data returned.
REQ-008 inst_sram_rdata  output  32  inst read data, valid when inst_sram_data_ok.
REQ-009 data_sram_req / data_sram_wr  input  1/1  data request / 1 = write.
REQ-010 data_sram_size  input  2  access size (0 byte, 1 half, 2 word).
REQ-011 data_sram_addr / data_sram_wdata  input  32/32  data address / write data.
REQ-012 data_sram_wstrb  input  4  byte enables.
REQ-013 data_sram_addr_ok / data_sram_data_ok  output  1/1  data address accepted / data read or write response returned.
REQ-014 data_sram_rdata  output  32  data read data, valid when data_sram_data_ok.
REQ-015 m_req, m_wr, m_size(2), m_addr(32), m_wstrb(4), m_wdata(32)  output  SRAM-like request to the AXI bridge.
REQ-016 m_addr_ok, m_data_ok  input  1/1  bridge address accept / response return; bridge answers strictly in acceptance order.
REQ-017 m_rdata  input  32  bridge read data, valid with m_data_ok.

Function
REQ-018 Grant FSM states SHALL be IDLE, GNT_I, GNT_D; reset state IDLE.
REQ-019 IDLE: if order FIFO full, stay IDLE; else if data_sram_req and not forced, go GNT_D; else if inst_sram_req, go GNT_I; forced = starve_cnt == STARVE_LIMIT and inst_sram_req.
REQ-020 GNT_x: m_req SHALL be 1 with fields muxed from the granted requester; on m_addr_ok go IDLE; grant SHALL NOT change before m_addr_ok.
REQ-021 In GNT_I, m_wr=0, m_size=2'b10, m_wstrb=4'b0, m_wdata=0.
REQ-022 Granted requester's addr_ok SHALL equal m_req & m_addr_ok in that cycle; non-granted addr_ok SHALL be 0.
REQ-023 Handshake (m_req & m_addr_ok) SHALL push source id (0 inst, 1 data) into the order FIFO.
REQ-024 m_data_ok SHALL pop the FIFO head; head 0 -> inst_sram_data_ok=1, inst_sram_rdata=m_rdata; head 1 -> data_sram_data_ok=1, data_sram_rdata=m_rdata; same-cycle combinational routing, zero added latency.
REQ-025 Simultaneous push and pop SHALL leave count unchanged; push SHALL be blocked when count == ORD_DEPTH, even if a pop occurs in that cycle.
REQ-026 m_data_ok with empty FIFO is illegal: no data_ok asserted, count unchanged, assertion flag for simulation.
REQ-027 Pointers SHALL wrap modulo ORD_DEPTH; count width clog2(ORD_DEPTH)+1.
REQ-028 starve_cnt SHALL increment (saturate at STARVE_LIMIT) when IDLE selects GNT_D while inst_sram_req=1, and clear to 0 on entry to GNT_I.
REQ-029 Latency: request visible on m_req one cycle after IDLE decision; back-to-back grants SHALL have one IDLE cycle between them.

Reset
REQ-030 On aresetn=0: FSM IDLE, FIFO count/pointers 0, starve_cnt 0, m_req 0, all addr_ok/data_ok 0, rdata outputs 0.
REQ-031 Reset mid-transaction SHALL discard all outstanding entries; bridge is reset by the same aresetn.

Structure
REQ-032 Shared package SHALL hold grant-state encodings, source-id constants (SRC_INST=0, SRC_DATA=1) and size encodings.
REQ-033 Order FIFO SHALL be sub-module sram_ord_fifo (1-bit entries, push/pop/full/empty/count).

Verification
REQ-034 Data and inst request same cycle, FIFO empty -> m_req with data addr first, data_sram_addr_ok on m_addr_ok, inst granted after one IDLE cycle.
REQ-035 Data requesting continuously, inst held, STARVE_LIMIT=8 -> after 8 data grants the 9th grant is inst; starve_cnt back to 0.
REQ-036 Bridge withholds m_data_ok, 4 accepts -> count=4, m_req stays 0; one m_data_ok -> next grant issues.
REQ-037 Accepts inst@0x1c000000, data read@0x80, inst@0x1c000004; m_rdata 0xA,0xB,0xC -> inst 0xA, data 0xB, inst 0xC in order.
REQ-038 Push and pop same cycle at count=2 -> count stays 2, head source routed correctly.
REQ-039 aresetn low with 3 outstanding, then late m_data_ok -> no data_ok asserted, FIFO empty.

Source files
------------

// File: rtl/sram_req_arbiter_pkg.sv
// Shared encodings for the SRAM request arbiter: grant states, source ids and access sizes.
package sram_req_arbiter_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StGntI = 2'd1,
    StGntD = 2'd2
  } gnt_state_e;

  localparam logic SRC_INST = 1'b0;
  localparam logic SRC_DATA = 1'b1;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

endpackage

// File: rtl/sram_req_arbiter_if.sv
// SRAM-like request/response bundle; master issues requests, slave accepts and answers.
interface sram_req_arbiter_if;
  logic        req;
  logic        wr;
  logic [1:0]  size;
  logic [31:0] addr;
  logic [3:0]  wstrb;
  logic [31:0] wdata;
  logic        addr_ok;
  logic        data_ok;
  logic [31:0] rdata;

  modport master (
    output req, wr, size, addr, wstrb, wdata,
    input  addr_ok, data_ok, rdata
  );

  modport slave (
    input  req, wr, size, addr, wstrb, wdata,
    output addr_ok, data_ok, rdata
  );
endinterface

// File: rtl/sram_req_arbiter_ord_fifo.sv
// Order FIFO of 1-bit source ids; remembers who owns each outstanding bridge transaction.
module sram_ord_fifo #(
  parameter int unsigned Depth = 4,
  localparam int unsigned PtrW = $clog2(Depth),
  localparam int unsigned CntW = PtrW + 1
) (
  input  logic            aclk,
  input  logic            aresetn,
  input  logic            push,
  input  logic            push_src,
  input  logic            pop,
  output logic            head,
  output logic            full,
  output logic            empty,
  output logic [CntW-1:0] count,
  output logic            underflow
);

  localparam logic [CntW-1:0] CntFull = CntW'(Depth);
  localparam logic [CntW-1:0] CntOne  = CntW'(1);
  localparam logic [PtrW-1:0] PtrOne  = PtrW'(1);

  logic [Depth-1:0] mem_q;
  logic [PtrW-1:0]  wptr_q, rptr_q;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             push_ok, pop_ok;

  assign full      = (cnt_q == CntFull);
  assign empty     = (cnt_q == '0);
  // A full FIFO refuses a push even when a pop frees a slot in the same cycle.
  assign push_ok   = push & ~full;
  assign pop_ok    = pop & ~empty;
  assign underflow = pop & empty;
  assign head      = mem_q[rptr_q];
  assign count     = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    unique case ({push_ok, pop_ok})
      2'b10:   cnt_d = cnt_q + CntOne;
      2'b01:   cnt_d = cnt_q - CntOne;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      mem_q  <= '0;
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (push_ok) begin
        mem_q[wptr_q] <= push_src;
        wptr_q        <= wptr_q + PtrOne;
      end
      if (pop_ok) begin
        rptr_q <= rptr_q + PtrOne;
      end
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/sram_req_arbiter.sv
// Arbitrates instruction and data SRAM-like requesters onto one bridge port and routes
// in-order responses back to their owners.
module sram_req_arbiter
  import sram_req_arbiter_pkg::*;
#(
  parameter int unsigned ORD_DEPTH    = 4,
  parameter int unsigned STARVE_LIMIT = 8
) (
  input  logic              aclk,
  input  logic              aresetn,
  sram_req_arbiter_if.slave  inst_sram,
  sram_req_arbiter_if.slave  data_sram,
  sram_req_arbiter_if.master m
);

  localparam int unsigned CntW = $clog2(ORD_DEPTH) + 1;
  localparam int unsigned StW  = $clog2(STARVE_LIMIT + 1);
  localparam logic [StW-1:0] StLimit = StW'(STARVE_LIMIT);
  localparam logic [StW-1:0] StOne   = StW'(1);

  gnt_state_e      state_q, state_d;
  logic [StW-1:0]  starve_q, starve_d;
  logic            full, empty, head, forced, hs, pop, pop_ok, ord_underflow;
  logic [CntW-1:0] ord_count;
  logic            m_wr;
  logic [1:0]      m_size;
  logic [31:0]     m_addr, m_wdata;
  logic [3:0]      m_wstrb;
  logic            unused_sink;

  assign forced = (starve_q == StLimit) & inst_sram.req;

  always_comb begin
    state_d  = state_q;
    starve_d = starve_q;
    unique case (state_q)
      StIdle: begin
        if (!full) begin
          if (data_sram.req && !forced) begin
            state_d = StGntD;
            if (inst_sram.req && (starve_q != StLimit)) starve_d = starve_q + StOne;
          end else if (inst_sram.req) begin
            state_d  = StGntI;
            starve_d = '0;
          end
        end
      end
      StGntI, StGntD: begin
        if (m.addr_ok) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q  <= StIdle;
      starve_q <= '0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
    end
  end

  // Instruction fetches are always word reads, whatever the inst port carries.
  always_comb begin
    m_wr    = 1'b0;
    m_size  = SIZE_WORD;
    m_addr  = inst_sram.addr;
    m_wstrb = '0;
    m_wdata = '0;
    if (state_q == StGntD) begin
      m_wr    = data_sram.wr;
      m_size  = data_sram.size;
      m_addr  = data_sram.addr;
      m_wstrb = data_sram.wstrb;
      m_wdata = data_sram.wdata;
    end
  end

  assign m.req   = aresetn & (state_q != StIdle);
  assign m.wr    = m_wr;
  assign m.size  = m_size;
  assign m.addr  = m_addr;
  assign m.wstrb = m_wstrb;
  assign m.wdata = m_wdata;

  assign hs                = m.req & m.addr_ok;
  assign inst_sram.addr_ok = hs & (state_q == StGntI);
  assign data_sram.addr_ok = hs & (state_q == StGntD);

  assign pop    = aresetn & m.data_ok;
  assign pop_ok = pop & ~empty;

  assign inst_sram.data_ok = pop_ok & (head == SRC_INST);
  assign data_sram.data_ok = pop_ok & (head == SRC_DATA);
  assign inst_sram.rdata   = inst_sram.data_ok ? m.rdata : '0;
  assign data_sram.rdata   = data_sram.data_ok ? m.rdata : '0;

  sram_ord_fifo #(
    .Depth (ORD_DEPTH)
  ) u_ord_fifo (
    .aclk      (aclk),
    .aresetn   (aresetn),
    .push      (hs),
    .push_src  (state_q == StGntD),
    .pop       (pop),
    .head      (head),
    .full      (full),
    .empty     (empty),
    .count     (ord_count),
    .underflow (ord_underflow)
  );

  // ord_underflow flags a response with nothing outstanding; probed in simulation only.
  assign unused_sink = ^{inst_sram.wr, inst_sram.size, inst_sram.wstrb, inst_sram.wdata,
                         ord_underflow};

endmodule
